race_arbiter_array: RTL and testbench

- Clocked, multi-channel successor to the combinational race arbiter used by the delay-based PUF.
- Resolves N_CH independent fin1/fin2 race pairs in parallel and latches one response bit per channel.
- Flags ties, timeouts and failed arming, and returns the full response word to the PUF controller over a start/valid/ack handshake.

---
 rtl/race_arbiter_array.sv | 181 ++++++++++++++++++
 tb/tb_race_arbiter_array.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/race_arbiter_array.sv
`timescale 1ns/1ps
// race_arbiter_array: resolves N_CH fin1/fin2 race pairs in parallel and
// returns a per-channel winner word over a start/valid/ack handshake.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, timeout_cycles   arm request (sampled in IDLE) and race-window length
//   fin1, fin2              per-channel path finishes, asynchronous to clk
//   resp_ack                controller accepts the response (sampled in DONE)
//   busy, armed, resp_valid FSM status (ARM/RACE/DONE, RACE, DONE)
//   resp, tie, undecided    per-channel winner, same-cycle tie, no-finish flags
//   arm_fail                fins did not all settle low during ARM
module race_arbiter_array #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [N_CH-1:0]      fin1,
    input  logic [N_CH-1:0]      fin2,
    input  logic                 resp_ack,
    output logic                 busy,
    output logic                 armed,
    output logic                 resp_valid,
    output logic [N_CH-1:0]      resp,
    output logic [N_CH-1:0]      tie,
    output logic [N_CH-1:0]      undecided,
    output logic                 arm_fail
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RACE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync1;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync2;
    logic [N_CH-1:0]      s1;
    logic [N_CH-1:0]      s2;

    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] t_q;
    logic [TIMEOUT_W-1:0] t_cap;
    logic [N_CH-1:0]      decided;
    logic [N_CH-1:0]      win1;
    logic [N_CH-1:0]      decided_nx;
    logic                 all_dec;
    logic                 fins_low;
    logic                 cnt_end;

    logic                 busy_d;
    logic                 armed_d;
    logic                 resp_valid_d;

    // Fin synchronisers; the last stage feeds every decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sync1[SYNC_STAGES-2:0], fin1};
            sync2 <= {sync2[SYNC_STAGES-2:0], fin2};
        end
    end

    assign s1 = sync1[SYNC_STAGES-1];
    assign s2 = sync2[SYNC_STAGES-1];

    // Per-channel decision terms for the current RACE cycle.
    always_comb begin
        t_cap      = (timeout_cycles == '0) ? TIMEOUT_W'(1) : timeout_cycles;
        win1       = ~decided & s1;
        decided_nx = decided | (s1 | s2);
        all_dec    = &decided_nx;
        fins_low   = ~(|s1) && ~(|s2);
        cnt_end    = (cnt == (t_q - TIMEOUT_W'(1)));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_ARM;
            S_ARM: begin
                if (fins_low)     state_nx = S_RACE;
                else if (cnt_end) state_nx = S_DONE;
            end
            S_RACE: if (all_dec || cnt_end) state_nx = S_DONE;
            S_DONE: if (resp_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so the registered
    // copies line up with the state register.
    always_comb begin
        busy_d       = (state_nx != S_IDLE);
        armed_d      = (state_nx == S_RACE);
        resp_valid_d = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            armed      <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            busy       <= busy_d;
            armed      <= armed_d;
            resp_valid <= resp_valid_d;
        end
    end

    // Window counter and response datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            t_q       <= '0;
            decided   <= '0;
            resp      <= '0;
            tie       <= '0;
            undecided <= '0;
            arm_fail  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        t_q       <= t_cap;
                        cnt       <= '0;
                        decided   <= '0;
                        resp      <= '0;
                        tie       <= '0;
                        undecided <= '0;
                        arm_fail  <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (fins_low) begin
                        cnt <= '0;
                    end else if (cnt_end) begin
                        arm_fail  <= 1'b1;
                        resp      <= '1;
                        undecided <= '1;
                    end else begin
                        cnt <= cnt + TIMEOUT_W'(1);
                    end
                end
                S_RACE: begin
                    decided <= decided_nx;
                    tie     <= tie | (win1 & s2);
                    if (cnt_end) begin
                        // Default-to-1 winner for channels still open at timeout.
                        resp      <= resp | win1 | ~decided_nx;
                        undecided <= ~decided_nx;
                    end else begin
                        resp <= resp | win1;
                        cnt  <= cnt + TIMEOUT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_race_arbiter_array.sv
`timescale 1ns/1ps
module tb_race_arbiter_array;

    localparam int unsigned N_CH        = 8;
    localparam int unsigned TIMEOUT_W   = 8;
    localparam int unsigned SYNC_STAGES = 2;

    typedef struct {
        logic [N_CH-1:0] resp;
        logic [N_CH-1:0] tie;
        logic [N_CH-1:0] und;
        logic            af;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic [TIMEOUT_W-1:0] timeout_cycles = '0;
    logic [N_CH-1:0]      fin1 = '0;
    logic [N_CH-1:0]      fin2 = '0;
    logic                 resp_ack = 1'b0;
    logic                 busy;
    logic                 armed;
    logic                 resp_valid;
    logic [N_CH-1:0]      resp;
    logic [N_CH-1:0]      tie;
    logic [N_CH-1:0]      undecided;
    logic                 arm_fail;

    int   n_checks = 0;
    int   n_err    = 0;
    int   arm_cnt  = 0;
    exp_t sb[$];

    race_arbiter_array #(
        .N_CH(N_CH), .TIMEOUT_W(TIMEOUT_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .timeout_cycles(timeout_cycles), .fin1(fin1), .fin2(fin2),
        .resp_ack(resp_ack), .busy(busy), .armed(armed),
        .resp_valid(resp_valid), .resp(resp), .tie(tie),
        .undecided(undecided), .arm_fail(arm_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (armed) arm_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_race(input logic [TIMEOUT_W-1:0] t);
        arm_cnt        = 0;
        start          = 1'b1;
        timeout_cycles = t;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_armed();
        int k = 0;
        while (!armed && k < 20) begin
            tick();
            k++;
        end
        chk("armed_wait", 32'(armed), 32'd1);
    endtask

    task automatic expect_resp(input logic [N_CH-1:0] r, input logic [N_CH-1:0] t,
                               input logic [N_CH-1:0] u, input logic af);
        exp_t e;
        e.resp = r; e.tie = t; e.und = u; e.af = af;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   k = 0;
        while (!resp_valid && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_resp"}, 32'(resp), 32'(e.resp));
                chk({tag, "_tie"}, 32'(tie), 32'(e.tie));
                chk({tag, "_undecided"}, 32'(undecided), 32'(e.und));
                chk({tag, "_arm_fail"}, 32'(arm_fail), 32'(e.af));
            end
        end
    endtask

    task automatic ack(input string tag);
        resp_ack = 1'b1;
        tick();
        resp_ack = 1'b0;
        chk({tag, "_ack_idle"}, 32'(busy), 32'd0);
        chk({tag, "_ack_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_outputs", 32'({busy, armed, resp_valid, arm_fail}), 32'd0);
        chk("rst_words", 32'({resp, tie, undecided}), 32'd0);
        tick();
        reset_n = 1'b1;
        ticks(2);

        // 1: clear winners, fins 10 cycles into the window, hold until ack.
        start_race(8'd16);
        chk("t1_busy_arm", 32'(busy), 32'd1);
        chk("t1_not_armed_yet", 32'(armed), 32'd0);
        wait_armed();
        chk("t1_arm_latency", 32'(arm_cnt), 32'd1);
        ticks(10);
        fin1 = 8'h0F;
        fin2 = 8'hF0;
        expect_resp(8'h0F, 8'h00, 8'h00, 1'b0);
        wait_done("t1");
        chk("t1_race_cycles", 32'(arm_cnt), 32'd13);
        fin1 = '0;
        fin2 = '0;
        ticks(3);
        chk("t1_hold_valid", 32'(resp_valid), 32'd1);
        chk("t1_hold_resp", 32'(resp), 32'h0F);
        ack("t1");

        // 2: channel 2 ties, the rest have clear winners.
        ticks(2);
        start_race(8'd16);
        wait_armed();
        fin1 = 8'h07;
        fin2 = 8'hFC;
        expect_resp(8'h07, 8'h04, 8'h00, 1'b0);
        wait_done("t2");
        chk("t2_first_cycle_decide", 32'(arm_cnt), 32'd3);
        fin1 = '0;
        fin2 = '0;
        ack("t2");

        // 3: T=5, channels 6-7 never finish.
        ticks(2);
        start_race(8'd5);
        wait_armed();
        fin2 = 8'h3F;
        expect_resp(8'hC0, 8'h00, 8'hC0, 1'b0);
        wait_done("t3");
        chk("t3_window_len", 32'(arm_cnt), 32'd5);
        chk("t3_armed_low", 32'(armed), 32'd0);
        fin2 = '0;
        ack("t3");

        // 4: fin1[0] stuck high through ARM.
        fin1 = 8'h01;
        ticks(3);
        start_race(8'd4);
        expect_resp(8'hFF, 8'h00, 8'hFF, 1'b1);
        wait_done("t4");
        chk("t4_never_armed", 32'(arm_cnt), 32'd0);
        fin1 = '0;
        ack("t4");

        // 5: reset mid-race after channel 1 decided, then a clean race.
        ticks(2);
        start_race(8'd16);
        wait_armed();
        fin1 = 8'h02;
        ticks(3);
        chk("t5_ch1_decided", 32'(resp), 32'h02);
        reset_n = 1'b0;
        fin1    = '0;
        #1;
        chk("t5_rst_status", 32'({busy, armed, resp_valid, arm_fail}), 32'd0);
        chk("t5_rst_resp", 32'({resp, tie, undecided}), 32'd0);
        tick();
        reset_n = 1'b1;
        ticks(2);
        start_race(8'd16);
        wait_armed();
        fin2 = 8'hFF;
        expect_resp(8'h00, 8'h00, 8'h00, 1'b0);
        wait_done("t5");
        fin2 = '0;
        ack("t5");

        // 6a: a decided channel ignores a later fin1 drop / fin2 rise.
        ticks(2);
        start_race(8'd16);
        wait_armed();
        fin1 = 8'h08;
        ticks(4);
        fin1 = 8'h00;
        fin2 = 8'h08;
        ticks(4);
        chk("t6_locked_resp", 32'(resp), 32'h08);
        fin2 = 8'hFF;
        expect_resp(8'h08, 8'h00, 8'h00, 1'b0);
        wait_done("t6a");
        fin2 = '0;
        // start in DONE and in the ack cycle is ignored.
        start = 1'b1;
        tick();
        chk("t6_start_in_done", 32'(resp_valid), 32'd1);
        resp_ack = 1'b1;
        tick();
        start    = 1'b0;
        resp_ack = 1'b0;
        chk("t6_ack_to_idle", 32'(busy), 32'd0);
        tick();
        chk("t6_no_restart", 32'(busy), 32'd0);

        // 6b: T=0 behaves as a one-cycle window.
        start_race(8'd0);
        wait_armed();
        expect_resp(8'hFF, 8'h00, 8'hFF, 1'b0);
        wait_done("t6b");
        chk("t6b_window_len", 32'(arm_cnt), 32'd1);
        ack("t6b");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
